// File: rtl/countdown_timer.sv
// countdown_timer: three-digit BCD countdown timer (00.0 to 99.9 s).
// In IDLE the preset is edited digit by digit with Sel/Up. Start runs the count
// down to zero, where the block enters DONE and raises the alarm.
// Optional feature macro: COUNTDOWN_BLINK_EN. When defined, the alarm blinks
// every 5 ticks in DONE. When undefined, the alarm is steady in DONE.
module countdown_timer #(
  parameter int LST_CLK = 100_000_000/10-1
) (
  input  logic       i_Clk,
  input  logic       i_Rst,
  input  logic       i_fStart,
  input  logic       i_fStop,
  input  logic       i_fSel,
  input  logic       i_fUp,
  output logic [6:0] o_Fnd0,
  output logic [6:0] o_Fnd1,
  output logic [6:0] o_Fnd2,
  output logic [2:0] o_Sel,
  output logic       o_Alarm,
  output logic [1:0] o_State
);

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    RUN   = 2'b01,
    PAUSE = 2'b10,
    DONE  = 2'b11
  } state_t;

  localparam logic [26:0] LAST_CNT = 27'(LST_CLK);

  state_t      state, state_next;
  logic        prev_start, prev_stop, prev_sel, prev_up;
  logic        press_start, press_stop, press_sel, press_up;
  logic [11:0] preset;
  logic [11:0] count;
  logic [11:0] disp;
  logic [26:0] presc;
  logic [1:0]  sel_idx;
  logic        tick;

  // Team FND decoder: BCD digit to segment pattern {g,f,e,d,c,b,a}, active high.
  function automatic logic [6:0] fnd(input logic [3:0] d);
    case (d)
      4'd0:    fnd = 7'h3F;
      4'd1:    fnd = 7'h06;
      4'd2:    fnd = 7'h5B;
      4'd3:    fnd = 7'h4F;
      4'd4:    fnd = 7'h66;
      4'd5:    fnd = 7'h6D;
      4'd6:    fnd = 7'h7D;
      4'd7:    fnd = 7'h07;
      4'd8:    fnd = 7'h7F;
      4'd9:    fnd = 7'h6F;
      default: fnd = 7'h00;
    endcase
  endfunction

  // Subtract one tenth from a three-digit BCD value, borrowing across digits.
  function automatic logic [11:0] bcd_dec(input logic [11:0] v);
    logic [11:0] r;
    r = v;
    if (v[3:0] != 4'd0) begin
      r[3:0] = v[3:0] - 4'd1;
    end else begin
      r[3:0] = 4'd9;
      if (v[7:4] != 4'd0) begin
        r[7:4] = v[7:4] - 4'd1;
      end else begin
        r[7:4]  = 4'd9;
        r[11:8] = v[11:8] - 4'd1;
      end
    end
    return r;
  endfunction

  function automatic logic [3:0] digit_inc(input logic [3:0] d);
    return (d == 4'd9) ? 4'd0 : d + 4'd1;
  endfunction

  assign press_start = prev_start & ~i_fStart;
  assign press_stop  = prev_stop  & ~i_fStop;
  assign press_sel   = prev_sel   & ~i_fSel;
  assign press_up    = prev_up    & ~i_fUp;
  assign tick        = (presc == LAST_CNT);

  // Remember last button levels so a press is one cycle wide however long it is held.
  always_ff @(posedge i_Clk or negedge i_Rst) begin
    if (!i_Rst) begin
      prev_start <= 1'b1;
      prev_stop  <= 1'b1;
      prev_sel   <= 1'b1;
      prev_up    <= 1'b1;
    end else begin
      prev_start <= i_fStart;
      prev_stop  <= i_fStop;
      prev_sel   <= i_fSel;
      prev_up    <= i_fUp;
    end
  end

  // State register.
  always_ff @(posedge i_Clk or negedge i_Rst) begin
    if (!i_Rst) state <= IDLE;
    else        state <= state_next;
  end

  // Next-state decision; Stop always wins over Start, and presses win over the tick.
  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (!press_stop && press_start && (preset != 12'h000)) state_next = RUN;
      RUN: begin
        if (press_stop)                        state_next = IDLE;
        else if (press_start)                  state_next = PAUSE;
        else if (tick && (count == 12'h001))   state_next = DONE;
      end
      PAUSE: begin
        if (press_stop)       state_next = IDLE;
        else if (press_start) state_next = RUN;
      end
      DONE:    if (press_start || press_stop) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Tick prescaler: cleared in IDLE, free-running in RUN, frozen while paused.
  always_ff @(posedge i_Clk or negedge i_Rst) begin
    if (!i_Rst) begin
      presc <= '0;
    end else begin
      case (state)
        IDLE:    presc <= '0;
        RUN:     presc <= tick ? '0 : presc + 27'd1;
`ifdef COUNTDOWN_BLINK_EN
        DONE:    presc <= tick ? '0 : presc + 27'd1;
`endif
        default: presc <= presc;
      endcase
    end
  end

  // Count loads the preset on Start and steps down one tenth per tick in RUN.
  always_ff @(posedge i_Clk or negedge i_Rst) begin
    if (!i_Rst) begin
      count <= '0;
    end else if ((state == IDLE) && (state_next == RUN)) begin
      count <= preset;
    end else if ((state == RUN) && tick && !press_start && !press_stop) begin
      count <= bcd_dec(count);
    end
  end

  // Preset editing in IDLE: Stop clears, Sel rotates the digit, Up bumps it.
  always_ff @(posedge i_Clk or negedge i_Rst) begin
    if (!i_Rst) begin
      preset  <= '0;
      sel_idx <= '0;
    end else if (state == IDLE) begin
      if (press_stop) begin
        preset  <= '0;
        sel_idx <= '0;
      end else if (press_sel) begin
        sel_idx <= (sel_idx == 2'd2) ? 2'd0 : sel_idx + 2'd1;
      end else if (press_up) begin
        case (sel_idx)
          2'd0:    preset[3:0]  <= digit_inc(preset[3:0]);
          2'd1:    preset[7:4]  <= digit_inc(preset[7:4]);
          default: preset[11:8] <= digit_inc(preset[11:8]);
        endcase
      end
    end
  end

`ifdef COUNTDOWN_BLINK_EN
  logic [2:0] blink_cnt;
  logic       alarm_q;

  // Alarm starts on at DONE entry and flips after every fifth tick spent in DONE.
  always_ff @(posedge i_Clk or negedge i_Rst) begin
    if (!i_Rst) begin
      blink_cnt <= '0;
      alarm_q   <= 1'b0;
    end else if ((state != DONE) && (state_next == DONE)) begin
      blink_cnt <= '0;
      alarm_q   <= 1'b1;
    end else if (state == DONE) begin
      if (tick) begin
        if (blink_cnt == 3'd4) begin
          blink_cnt <= '0;
          alarm_q   <= ~alarm_q;
        end else begin
          blink_cnt <= blink_cnt + 3'd1;
        end
      end
    end else begin
      blink_cnt <= '0;
      alarm_q   <= 1'b0;
    end
  end

  assign o_Alarm = alarm_q & (state == DONE);
`else
  assign o_Alarm = (state == DONE);
`endif

  // Displays show the preset while editing and the running count otherwise.
  always_comb begin
    disp    = (state == IDLE) ? preset : count;
    o_Fnd0  = fnd(disp[3:0]);
    o_Fnd1  = fnd(disp[7:4]);
    o_Fnd2  = fnd(disp[11:8]);
    o_Sel   = (state == IDLE) ? (3'b001 << sel_idx) : 3'b000;
    o_State = state;
  end

endmodule

// File: tb/tb_countdown_timer.sv
// tb_countdown_timer: randomized and directed stimulus for countdown_timer,
// scored against a tenths-based behavioural model through an expectation queue.
module tb_countdown_timer;

  localparam int LST = 4;

  logic       i_Clk = 1'b0;
  logic       i_Rst;
  logic       i_fStart, i_fStop, i_fSel, i_fUp;
  logic [6:0] o_Fnd0, o_Fnd1, o_Fnd2;
  logic [2:0] o_Sel;
  logic       o_Alarm;
  logic [1:0] o_State;

  int checks = 0;
  int errors = 0;
  logic [26:0] exp_q [$];

  // Reference model state: values held as plain integers of tenths.
  int m_state, m_preset, m_count, m_sel, m_phase, m_ticks;
  bit m_alarm;
  bit m_pstart, m_pstop, m_psel, m_pup;

  countdown_timer #(.LST_CLK(LST)) dut (
    .i_Clk   (i_Clk),
    .i_Rst   (i_Rst),
    .i_fStart(i_fStart),
    .i_fStop (i_fStop),
    .i_fSel  (i_fSel),
    .i_fUp   (i_fUp),
    .o_Fnd0  (o_Fnd0),
    .o_Fnd1  (o_Fnd1),
    .o_Fnd2  (o_Fnd2),
    .o_Sel   (o_Sel),
    .o_Alarm (o_Alarm),
    .o_State (o_State)
  );

  // 100 MHz-style free-running clock.
  always #5 i_Clk = ~i_Clk;

  function automatic logic [6:0] fnd(input int d);
    case (d)
      0: return 7'h3F;
      1: return 7'h06;
      2: return 7'h5B;
      3: return 7'h4F;
      4: return 7'h66;
      5: return 7'h6D;
      6: return 7'h7D;
      7: return 7'h07;
      8: return 7'h7F;
      9: return 7'h6F;
      default: return 7'h00;
    endcase
  endfunction

  function automatic int bump_digit(input int p, input int idx);
    int w, d;
    w = (idx == 0) ? 1 : (idx == 1) ? 10 : 100;
    d = (p / w) % 10;
    return p - d * w + ((d + 1) % 10) * w;
  endfunction

  function automatic logic [26:0] model_outputs();
    int  v;
    bit  alarm;
    v     = (m_state == 0) ? m_preset : m_count;
    alarm = (m_state == 3) && m_alarm;
    return {2'(m_state), (m_state == 0) ? 3'(1 << m_sel) : 3'b000, alarm,
            fnd((v / 100) % 10), fnd((v / 10) % 10), fnd(v % 10)};
  endfunction

  task automatic model_reset();
    m_state = 0; m_preset = 0; m_count = 0; m_sel = 0;
    m_phase = 0; m_ticks = 0; m_alarm = 0;
    m_pstart = 1; m_pstop = 1; m_psel = 1; m_pup = 1;
  endtask

  task automatic model_step(input bit s, input bit st, input bit se, input bit u);
    bit p_s, p_st, p_se, p_u, tk;
    int old_preset;
    p_s  = m_pstart && !s;
    p_st = m_pstop && !st;
    p_se = m_psel && !se;
    p_u  = m_pup && !u;
    tk   = (m_phase == LST);
    old_preset = m_preset;
    case (m_state)
      0: begin
        m_phase = 0;
        if (p_st) begin
          m_preset = 0;
          m_sel    = 0;
        end else begin
          if (p_se)     m_sel    = (m_sel + 1) % 3;
          else if (p_u) m_preset = bump_digit(m_preset, m_sel);
          if (p_s && old_preset != 0) begin
            m_count = old_preset;
            m_state = 1;
          end
        end
      end
      1: begin
        m_phase = tk ? 0 : m_phase + 1;
        if (p_st)     m_state = 0;
        else if (p_s) m_state = 2;
        else if (tk) begin
          m_count = m_count - 1;
          if (m_count == 0) begin
            m_state = 3;
            m_alarm = 1;
            m_ticks = 0;
          end
        end
      end
      2: begin
        if (p_st)     m_state = 0;
        else if (p_s) m_state = 1;
      end
      default: begin
`ifdef COUNTDOWN_BLINK_EN
        m_phase = tk ? 0 : m_phase + 1;
        if (tk) begin
          m_ticks = m_ticks + 1;
          if (m_ticks == 5) begin
            m_ticks = 0;
            m_alarm = !m_alarm;
          end
        end
`endif
        if (p_s || p_st) m_state = 0;
      end
    endcase
    m_pstart = s; m_pstop = st; m_psel = se; m_pup = u;
  endtask

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp_v);
    checks++;
    if (act !== exp_v) begin
      errors++;
      $display("[TB] FAIL %s actual=%0h expected=%0h at %0t", name, act, exp_v, $time);
    end
  endtask

  // Drive button levels for n cycles; each cycle queues the model's post-edge outputs.
  task automatic applyStimulus(input bit s, input bit st, input bit se, input bit u, input int n);
    for (int k = 0; k < n; k++) begin
      @(negedge i_Clk);
      i_fStart = s; i_fStop = st; i_fSel = se; i_fUp = u;
      model_step(s, st, se, u);
      exp_q.push_back(model_outputs());
      @(posedge i_Clk);
      #2;
    end
  endtask

  task automatic release_all(input int n);
    applyStimulus(1, 1, 1, 1, n);
  endtask

  task automatic press(input bit s, input bit st, input bit se, input bit u);
    applyStimulus(s, st, se, u, 1);
    release_all(1);
  endtask

  task automatic wait_done(output int n);
    n = 0;
    while (o_State !== 2'b11 && n < 400) begin
      release_all(1);
      n++;
    end
  endtask

  // Monitor: after every edge, pop the next expected snapshot and compare.
  initial begin : monitor
    logic [26:0] e;
    forever begin
      @(posedge i_Clk);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        checkOutput("snapshot{state,sel,alarm,fnd2,fnd1,fnd0}",
                    {o_State, o_Sel, o_Alarm, o_Fnd2, o_Fnd1, o_Fnd0}, e);
      end
    end
  end

  // Main sequence: directed scenarios first, then random button traffic.
  initial begin : stimulus
    int n;
    i_Rst = 0; i_fStart = 1; i_fStop = 1; i_fSel = 1; i_fUp = 1;
    model_reset();
    #1;
    checkOutput("reset_state", o_State, 2'b00);
    checkOutput("reset_sel", o_Sel, 3'b001);
    checkOutput("reset_alarm", o_Alarm, 1'b0);
    checkOutput("reset_fnd", {o_Fnd2, o_Fnd1, o_Fnd0}, {fnd(0), fnd(0), fnd(0)});
    @(negedge i_Clk);
    @(negedge i_Clk);
    i_Rst = 1;

    $display("[TB] preset 01.2 run");
    press(1, 1, 1, 0);
    press(1, 1, 1, 0);
    press(1, 1, 0, 1);
    press(1, 1, 1, 0);
    checkOutput("preset_012_fnd", {o_Fnd2, o_Fnd1, o_Fnd0}, {fnd(0), fnd(1), fnd(2)});
    checkOutput("preset_012_sel", o_Sel, 3'b010);
    applyStimulus(0, 1, 1, 1, 1);
    checkOutput("start_to_run", o_State, 2'b01);
    wait_done(n);
    checkOutput("run_012_clocks", n, 60);
    checkOutput("done_alarm", o_Alarm, 1'b1);
    checkOutput("done_fnd", {o_Fnd2, o_Fnd1, o_Fnd0}, {fnd(0), fnd(0), fnd(0)});

    $display("[TB] borrow from 10.0");
    press(1, 0, 1, 1);
    press(1, 0, 1, 1);
    press(1, 1, 0, 1);
    press(1, 1, 0, 1);
    press(1, 1, 1, 0);
    applyStimulus(0, 1, 1, 1, 1);
    release_all(5);
    checkOutput("borrow_099", {o_Fnd2, o_Fnd1, o_Fnd0}, {fnd(0), fnd(9), fnd(9)});
    release_all(5);
    checkOutput("borrow_098", {o_Fnd2, o_Fnd1, o_Fnd0}, {fnd(0), fnd(9), fnd(8)});

    $display("[TB] stop behaviour");
    release_all(125);
    checkOutput("count_073", {o_Fnd2, o_Fnd1, o_Fnd0}, {fnd(0), fnd(7), fnd(3)});
    applyStimulus(1, 0, 1, 1, 1);
    checkOutput("stop_to_idle", o_State, 2'b00);
    checkOutput("stop_shows_preset", {o_Fnd2, o_Fnd1, o_Fnd0}, {fnd(1), fnd(0), fnd(0)});
    release_all(1);
    applyStimulus(1, 0, 1, 1, 1);
    checkOutput("stop_clears", {o_Fnd2, o_Fnd1, o_Fnd0}, {fnd(0), fnd(0), fnd(0)});
    checkOutput("stop_sel_reset", o_Sel, 3'b001);
    release_all(1);
    applyStimulus(0, 1, 1, 1, 1);
    checkOutput("start_zero_ignored", o_State, 2'b00);
    release_all(1);

    $display("[TB] pause and resume");
    for (int i = 0; i < 5; i++) press(1, 1, 1, 0);
    applyStimulus(0, 1, 1, 1, 1);
    release_all(6);
    applyStimulus(0, 1, 1, 1, 1);
    checkOutput("pause_state", o_State, 2'b10);
    checkOutput("pause_count", o_Fnd0, fnd(4));
    release_all(100);
    checkOutput("pause_hold_state", o_State, 2'b10);
    checkOutput("pause_hold_count", o_Fnd0, fnd(4));
    applyStimulus(0, 1, 1, 1, 1);
    wait_done(n);
    checkOutput("resume_clocks", n, 18);
    checkOutput("resume_alarm", o_Alarm, 1'b1);

    $display("[TB] simultaneous and held presses");
    press(1, 0, 1, 1);
    applyStimulus(0, 1, 1, 1, 1);
    release_all(3);
    applyStimulus(0, 0, 1, 1, 1);
    checkOutput("start_stop_same_edge", o_State, 2'b00);
    release_all(1);
    applyStimulus(1, 1, 0, 0, 1);
    checkOutput("sel_beats_up_sel", o_Sel, 3'b010);
    checkOutput("sel_beats_up_preset", {o_Fnd2, o_Fnd1, o_Fnd0}, {fnd(0), fnd(0), fnd(5)});
    release_all(1);
    applyStimulus(1, 1, 1, 0, 50);
    release_all(1);
    checkOutput("held_up_once", {o_Fnd2, o_Fnd1, o_Fnd0}, {fnd(0), fnd(1), fnd(5)});

    $display("[TB] reset mid-run");
    applyStimulus(0, 1, 1, 1, 1);
    release_all(20);
    @(negedge i_Clk);
    i_Rst = 0;
    model_reset();
    #1;
    checkOutput("async_reset_state", o_State, 2'b00);
    checkOutput("async_reset_alarm", o_Alarm, 1'b0);
    checkOutput("async_reset_fnd", {o_Fnd2, o_Fnd1, o_Fnd0}, {fnd(0), fnd(0), fnd(0)});
    @(negedge i_Clk);
    @(negedge i_Clk);
    i_Rst = 1;

    $display("[TB] random traffic");
    for (int i = 0; i < 4000; i++) begin
      applyStimulus($urandom_range(0, 39) != 0, $urandom_range(0, 199) != 0,
                    $urandom_range(0, 9) != 0, $urandom_range(0, 3) != 0, 1);
    end

    release_all(2);
    @(posedge i_Clk);
    #3;
    checkOutput("queue_drained", exp_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/countdown_timer.md
# countdown_timer

Three-digit BCD countdown timer (00.0–99.9 s): the down-counting counterpart of the team's stopwatch, sharing its active-low push-button inputs and per-digit 7-segment outputs. In IDLE the user edits a preset digit by digit; START runs the count down to zero, where the block raises an alarm. It sits between the board push-buttons and three FND displays on the 100 MHz board clock.

## Interface
- LST_CLK, 100_000_000/10-1: last value of the tick prescaler; one count step (0.1 s) every LST_CLK+1 clocks; legal range 1..2^27-1.
- i_Clk  in  1  system clock, rising edge.
- i_Rst  in  1  reset: asynchronous, active-low.
- i_fStart  in  1  START/PAUSE button, active-low, raw level.
- i_fStop  in  1  STOP/CLEAR button, active-low, raw level.
- i_fSel  in  1  digit-select button, active-low.
- i_fUp  in  1  digit-increment button, active-low.
- o_Fnd0 / o_Fnd1 / o_Fnd2  out  7 each  7-segment pattern of the tenths, seconds-units and seconds-tens digits, produced by the team's FND decoder.
- o_Sel  out  3  one-hot selected digit (bit0 = tenths) in IDLE; 3'b000 in other states.
- o_Alarm  out  1  alarm indicator.
- o_State  out  2  current state: IDLE=00, RUN=01, PAUSE=10, DONE=11.

## Operation
- Press detection: one previous-level register per button, reset to 1. A press is `prev==1 && input==0`, evaluated combinationally and acted on at the next rising edge. It is one cycle wide regardless of how long the button is held. No debouncing is done in this block.
- Registers: preset P2..P0 (BCD), count C2..C0 (BCD), 27-bit prescaler, 2-bit select index, state.
- Display: IDLE shows the preset; RUN, PAUSE and DONE show the count.
- IDLE:
  - Prescaler held at 0.
  - Sel press: select index goes 0→1→2→0.
  - Up press: selected preset digit becomes (digit+1) mod 10.
  - Stop press: preset cleared to 000 and select index reset to 0.
  - Start press with preset ≠ 000: count loads the preset and the state goes to RUN.
  - Start press with preset == 000: ignored.
- RUN:
  - Prescaler counts 0..LST_CLK and wraps. On the wrap (tick), the count decrements by one tenth, with BCD borrow (x.0 → (x-1).9, 10.0 → 09.9).
  - On the tick where the count is 00.1, the count becomes 00.0 and the state becomes DONE on the same edge.
  - Start press → PAUSE.
  - Stop press → IDLE.
- PAUSE:
  - Prescaler and count hold.
  - Start press → RUN, with the prescaler resuming from its held value.
  - Stop press → IDLE.
- DONE:
  - Count holds at 000; o_Alarm is active.
  - Start or Stop press → IDLE.
- Entering IDLE from any state: the preset is retained, so the display shows the preset again.
- Sel and Up are ignored outside IDLE.
- Priority:
  - Stop beats Start when both are pressed in the same cycle.
  - In IDLE, Sel beats Up in the same cycle; that Up press is dropped.
  - A Start or Stop press in RUN on a tick edge beats the decrement. The count does not change on that edge.

## Timing
- Reset values: state IDLE, preset 000, count 000, prescaler 0, select 0, all previous-level registers 1. Outputs: o_Fnd0..2 = FND(0), o_Sel = 001, o_Alarm = 0, o_State = 00.
- Reset asserted mid-run aborts immediately, with no alarm.
- Start press to o_State=01: one clock.
- First decrement: LST_CLK+1 clocks after entering RUN from IDLE.
- Full-run duration from preset N tenths: N×(LST_CLK+1) clocks from the RUN entry edge to DONE, excluding pauses.
- All outputs are registered-state driven; there are no combinational paths from the button inputs to the outputs.

## Configuration
- COUNTDOWN_BLINK_EN:
  - Defined: in DONE, o_Alarm toggles every 5 ticks (0.5 s at default LST_CLK). The prescaler keeps running in DONE to pace the toggle, and o_Alarm is 1 on DONE entry.
  - Undefined: o_Alarm is a steady 1 in DONE.
  - Both builds: o_Alarm = 0 in all other states.

## Test plan
All directed scenarios run with LST_CLK=4, i.e. 5 clocks per tick.
- Reset with buttons released → o_State=00, o_Sel=001, o_Alarm=0, all displays FND(0).
- Preset 01.2:
  - Stimulus: Up ×2, Sel, Up; then Start.
  - Before Start: display 01.2, o_Sel=010.
  - After Start: o_State=01 next edge; DONE and o_Alarm=1 exactly 60 clocks after RUN entry; display 00.0.
- Borrow:
  - Stimulus: preset 10.0, Start, wait 5 clocks.
  - Display 09.9; after a further 5 clocks, 09.8.
- Pause:
  - Stimulus: preset 00.5, Start, press Start at clock 7, wait 100 clocks, press Start again.
  - Count holds at 00.4 and o_State=10 throughout the pause.
  - After resume, DONE arrives 18 clocks after the resuming edge (prescaler resumes at 2).
- Stop behaviour:
  - Stop during RUN at 07.3 from preset 10.0 → IDLE, display 10.0.
  - A second Stop → display 00.0, o_Sel=001.
  - Start with preset 000 → o_State stays 00.
- Simultaneous and held presses:
  - Start and Stop pressed on the same edge in RUN → IDLE.
  - Sel and Up pressed together in IDLE → select advances and the preset is unchanged.
  - Holding Up low for 50 clocks → exactly one increment.
